vram_port: RTL

Single-port SRAM responder behind the video CRT controller's fetch interface. It services the controller's `VAD`/`vram_cs` read requests, returning `VDI` with a `vram_complete` pulse, and arbitrates those reads against CPU byte reads and writes to the same external 64 KB SRAM. It sits between the video CRT controller, the CPU bus decoder and the SRAM pins.

---
 rtl/vram_pkg.sv | 22 ++
 rtl/vram_req_arm.sv | 41 ++++
 rtl/vram_port.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/vram_pkg.sv
// Shared definitions for the video SRAM port.
// Holds the FSM state encoding, the default number of SRAM wait states and
// the inactive level of the active-low SRAM strobes.
package vram_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StVidRd   = 3'd1,
    StVidDone = 3'd2,
    StCpuRd   = 3'd3,
    StCpuWr   = 3'd4,
    StCpuDone = 3'd5
  } state_e;

  localparam int unsigned WaitStatesDefault = 1;
  localparam int unsigned WaitCntW          = 3;

  // SRAM strobes are active low.
  localparam logic StrobeOff = 1'b1;
  localparam logic StrobeOn  = 1'b0;

endpackage

// File: rtl/vram_req_arm.sv
// Per-requester armed flag and eligibility.
// A level request is eligible only while armed; the flag clears when the
// requester's access completes and re-arms whenever the line is seen low, so a
// request line held high across its completion is not serviced a second time.
//   clk, rst   : clock, synchronous active-high reset (reset arms the flag)
//   req_i      : request level from the requester
//   done_i     : high in the completion cycle of this requester's access
//   eligible_o : request may be accepted by the arbiter this cycle
module vram_req_arm
  import vram_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic done_i,
  output logic eligible_o
);

  logic armed_q, armed_d;

  // A low line wins over completion so a dropped request re-arms immediately.
  always_comb begin
    armed_d = armed_q;
    if (!req_i) begin
      armed_d = 1'b1;
    end else if (done_i) begin
      armed_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q <= 1'b1;
    end else begin
      armed_q <= armed_d;
    end
  end

  assign eligible_o = req_i & armed_q;

endmodule

// File: rtl/vram_port.sv
// SRAM responder shared by the video fetch interface and the CPU bus.
// Arbitrates video reads (strict priority) and CPU byte reads/writes onto a
// single external 64 KB asynchronous SRAM. All outputs are registered; the
// strobes follow the FSM state one cycle later, with SA/sram_do captured on
// the edge that enters an access so address and data lead the strobes.
//   clk, rst             : clock, synchronous active-high reset
//   VAD, vram_cs         : video read address / request level
//   VDI, vram_complete   : video read data / one-cycle completion pulse
//   cpu_cs, cpu_rw       : CPU request level, 1 = read / 0 = write
//   cpu_AD, cpu_DI       : CPU address / write data
//   cpu_DO, cpu_ready    : CPU read data / one-cycle completion pulse
//   SA, sram_do, sram_di : SRAM address, write data, read data
//   sram_oe              : drive enable for the SRAM data pins
//   SCE_n, SOE_n, SWE_n  : SRAM chip, output and write enables (active low)
module vram_port
  import vram_pkg::*;
#(
  parameter int unsigned WAIT_STATES = WaitStatesDefault
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] VAD,
  input  logic        vram_cs,
  output logic [7:0]  VDI,
  output logic        vram_complete,
  input  logic        cpu_cs,
  input  logic        cpu_rw,
  input  logic [15:0] cpu_AD,
  input  logic [7:0]  cpu_DI,
  output logic [7:0]  cpu_DO,
  output logic        cpu_ready,
  output logic [15:0] SA,
  output logic [7:0]  sram_do,
  input  logic [7:0]  sram_di,
  output logic        sram_oe,
  output logic        SCE_n,
  output logic        SOE_n,
  output logic        SWE_n
);

  localparam logic [WaitCntW-1:0] LastWait = WaitCntW'(WAIT_STATES);

  state_e state_q, state_d;
  logic [WaitCntW-1:0] wait_q, wait_d;
  logic is_wr_q, is_wr_d;
  logic [15:0] sa_q, sa_d;
  logic [7:0] sdo_q, sdo_d;
  logic [7:0] vdi_q, vdi_d;
  logic [7:0] cdo_q, cdo_d;
  logic vcmp_q, vcmp_d;
  logic crdy_q, crdy_d;
  logic oe_q, oe_d;
  logic sce_n_q, sce_n_d;
  logic soe_n_q, soe_n_d;
  logic swe_n_q, swe_n_d;

  logic vid_elig, cpu_elig;
  logic vid_done, cpu_done;

  assign vid_done = (state_q == StVidDone);
  assign cpu_done = (state_q == StCpuDone);

  vram_req_arm u_vid_arm (
    .clk        (clk),
    .rst        (rst),
    .req_i      (vram_cs),
    .done_i     (vid_done),
    .eligible_o (vid_elig)
  );

  vram_req_arm u_cpu_arm (
    .clk        (clk),
    .rst        (rst),
    .req_i      (cpu_cs),
    .done_i     (cpu_done),
    .eligible_o (cpu_elig)
  );

  // Next state, wait counter and access registers.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    is_wr_d = is_wr_q;
    sa_d    = sa_q;
    sdo_d   = sdo_q;
    unique case (state_q)
      StIdle: begin
        wait_d = '0;
        if (vid_elig) begin
          state_d = StVidRd;
          sa_d    = VAD;
          is_wr_d = 1'b0;
        end else if (cpu_elig) begin
          sa_d    = cpu_AD;
          is_wr_d = ~cpu_rw;
          if (cpu_rw) begin
            state_d = StCpuRd;
          end else begin
            state_d = StCpuWr;
            sdo_d   = cpu_DI;
          end
        end
      end
      StVidRd: begin
        if (wait_q == LastWait) begin
          state_d = StVidDone;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StCpuRd, StCpuWr: begin
        if (wait_q == LastWait) begin
          state_d = StCpuDone;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StVidDone, StCpuDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Registered pin and completion outputs, decoded from the current state.
  always_comb begin
    sce_n_d = StrobeOff;
    soe_n_d = StrobeOff;
    swe_n_d = StrobeOff;
    oe_d    = 1'b0;
    vcmp_d  = 1'b0;
    crdy_d  = 1'b0;
    vdi_d   = vdi_q;
    cdo_d   = cdo_q;
    unique case (state_q)
      StVidRd, StCpuRd: begin
        sce_n_d = StrobeOn;
        soe_n_d = StrobeOn;
      end
      StCpuWr: begin
        sce_n_d = StrobeOn;
        swe_n_d = StrobeOn;
        oe_d    = 1'b1;
      end
      StVidDone: begin
        // sram_di still reflects the last strobed read cycle here.
        vcmp_d = 1'b1;
        vdi_d  = sram_di;
      end
      StCpuDone: begin
        crdy_d = 1'b1;
        // Keep driving write data one cycle past SWE_n rising for hold time.
        oe_d   = is_wr_q;
        if (!is_wr_q) begin
          cdo_d = sram_di;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      wait_q  <= '0;
      is_wr_q <= 1'b0;
      sa_q    <= '0;
      sdo_q   <= '0;
      vdi_q   <= '0;
      cdo_q   <= '0;
      vcmp_q  <= 1'b0;
      crdy_q  <= 1'b0;
      oe_q    <= 1'b0;
      sce_n_q <= StrobeOff;
      soe_n_q <= StrobeOff;
      swe_n_q <= StrobeOff;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      is_wr_q <= is_wr_d;
      sa_q    <= sa_d;
      sdo_q   <= sdo_d;
      vdi_q   <= vdi_d;
      cdo_q   <= cdo_d;
      vcmp_q  <= vcmp_d;
      crdy_q  <= crdy_d;
      oe_q    <= oe_d;
      sce_n_q <= sce_n_d;
      soe_n_q <= soe_n_d;
      swe_n_q <= swe_n_d;
    end
  end

  assign VDI           = vdi_q;
  assign vram_complete = vcmp_q;
  assign cpu_DO        = cdo_q;
  assign cpu_ready     = crdy_q;
  assign SA            = sa_q;
  assign sram_do       = sdo_q;
  assign sram_oe       = oe_q;
  assign SCE_n         = sce_n_q;
  assign SOE_n         = soe_n_q;
  assign SWE_n         = swe_n_q;

endmodule
